// File: rtl/keylock_pkg.sv
// Shared keylock definitions: control key codes, scan FSM states and the keypad
// (row,col) -> keypress code table.
package keylock_pkg;

  localparam logic [3:0] KEY_CANCEL = 4'd7;
  localparam logic [3:0] KEY_REPRO  = 4'd8;
  localparam logic [3:0] KEY_LOCK   = 4'd9;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  // Keypad layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_encode(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = 4'd10;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = 4'd11;
      4'h8:    code = KEY_CANCEL;
      4'h9:    code = KEY_REPRO;
      4'hA:    code = KEY_LOCK;
      4'hB:    code = 4'd12;
      4'hC:    code = 4'd14;
      4'hD:    code = 4'd0;
      4'hE:    code = 4'd15;
      4'hF:    code = 4'd13;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad rows; idles at
// "no key" (all ones) out of reset.
module keypad_sync (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] d_in,
  output logic [3:0] q_out
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  // Next values of the synchronizer chain.
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad column scanner with debounce: issues one rdy strobe and keypress
// code per accepted press, and tracks key_held until the release is accepted.
module keypad_scan_encoder #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] keypress,
  output logic       rdy,
  output logic       key_held
);
  import keylock_pkg::*;

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [DW-1:0] DWELL_ZERO = DW'(0);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

  logic [3:0]    row_sync_s;
  logic          tick_s, row_none_s, row_single_s, advance_s;
  logic [1:0]    row_idx_s;
  logic [CW-1:0] dbcnt_inc_s;

  scan_state_e   state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] dbcnt_q, dbcnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    col_n_q, col_n_d;
  logic [3:0]    keypress_q, keypress_d;
  logic          rdy_q, rdy_d;
  logic          key_held_q, key_held_d;

  keypad_sync u_sync (
    .clk    (clk),
    .resetN (resetN),
    .d_in   (row_n),
    .q_out  (row_sync_s)
  );

  // Classify the synchronized row sample as none / single (with its row) / multi.
  always_comb begin
    row_none_s = (row_sync_s == 4'b1111);
    case (row_sync_s)
      4'b1110: begin row_single_s = 1'b1; row_idx_s = 2'd0; end
      4'b1101: begin row_single_s = 1'b1; row_idx_s = 2'd1; end
      4'b1011: begin row_single_s = 1'b1; row_idx_s = 2'd2; end
      4'b0111: begin row_single_s = 1'b1; row_idx_s = 2'd3; end
      default: begin row_single_s = 1'b0; row_idx_s = 2'd0; end
    endcase
  end

  // Dwell counter, scan FSM, debounce counter and output next-state logic.
  always_comb begin
    tick_s      = (dwell_q == DWELL_LAST);
    dwell_d     = tick_s ? DWELL_ZERO : (dwell_q + DWELL_ONE);
    dbcnt_inc_s = dbcnt_q + CNT_ONE;
    state_d     = state_q;
    dbcnt_d     = dbcnt_q;
    row_d       = row_q;
    keypress_d  = keypress_q;
    key_held_d  = key_held_q;
    rdy_d       = 1'b0;
    advance_s   = 1'b0;
    if (tick_s) begin
      case (state_q)
        SCAN: begin
          if (row_single_s) begin
            row_d   = row_idx_s;
            dbcnt_d = CNT_ONE;
            state_d = DEBOUNCE;
          end else begin
            advance_s = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_single_s && (row_idx_s == row_q)) begin
            if (dbcnt_inc_s == CNT_TARGET) begin
              rdy_d      = 1'b1;
              keypress_d = key_encode(row_q, col_idx_q);
              key_held_d = 1'b1;
              dbcnt_d    = CNT_ZERO;
              state_d    = HELD;
            end else begin
              dbcnt_d = dbcnt_inc_s;
            end
          end else begin
            // A failed debounce re-examines the same column on the next tick.
            dbcnt_d = CNT_ZERO;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (row_none_s) begin
            dbcnt_d = CNT_ONE;
            state_d = RELEASE;
          end else begin
            state_d = HELD;
          end
        end
        RELEASE: begin
          if (!row_none_s) begin
            dbcnt_d = CNT_ZERO;
            state_d = HELD;
          end else if (dbcnt_inc_s == CNT_TARGET) begin
            key_held_d = 1'b0;
            dbcnt_d    = CNT_ZERO;
            state_d    = SCAN;
            advance_s  = 1'b1;
          end else begin
            dbcnt_d = dbcnt_inc_s;
          end
        end
        default: begin
          dbcnt_d = CNT_ZERO;
          state_d = SCAN;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    col_idx_d = advance_s ? (col_idx_q + 2'd1) : col_idx_q;
    col_n_d   = ~(4'b0001 << col_idx_d);
  end

  // All scanner state and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= SCAN;
      dwell_q    <= DWELL_ZERO;
      dbcnt_q    <= CNT_ZERO;
      col_idx_q  <= 2'd0;
      row_q      <= 2'd0;
      col_n_q    <= 4'b1110;
      keypress_q <= 4'h0;
      rdy_q      <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      dbcnt_q    <= dbcnt_d;
      col_idx_q  <= col_idx_d;
      row_q      <= row_d;
      col_n_q    <= col_n_d;
      keypress_q <= keypress_d;
      rdy_q      <= rdy_d;
      key_held_q <= key_held_d;
    end
  end

  assign col_n    = col_n_q;
  assign keypress = keypress_q;
  assign rdy      = rdy_q;
  assign key_held = key_held_q;

endmodule
